// File: rtl/tlm_sb_rx_queue.sv
// Sideband ingress queue: separate posted/non-posted flit FIFOs, store-and-forward message delivery, credit return.
// Optional overflow/protocol checking is enabled by defining TLM_SB_RX_OVF_CHK_EN.

module tlm_sb_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [8:0] wdata,
    input  logic       pop,
    output logic [8:0] rdata,
    output logic       full,
    output logic       msg_avail
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] msg_cnt_q, msg_cnt_d;
    logic [8:0]    mem_q [DEPTH];

    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign msg_avail = (msg_cnt_q != {PW{1'b0}});

    // Pointer and complete-message count next-state; bit 8 of a flit is its EOM marker.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        msg_cnt_d = msg_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push & wdata[8], pop & rdata[8]})
            2'b10:   msg_cnt_d = msg_cnt_q + PW'(1);
            2'b01:   msg_cnt_d = msg_cnt_q - PW'(1);
            default: msg_cnt_d = msg_cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            msg_cnt_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            msg_cnt_q <= msg_cnt_d;
        end
    end

    // Flit storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

`ifdef TLM_SB_RX_OVF_CHK_EN
module tlm_sb_rx_queue_chk (
    input logic clk,
    input logic rst_n,
    input logic viol
);
    // Flags fabric credit/protocol violations seen on the ingress side.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!viol) else $error("tlm_sb_rx_queue: sideband ingress protocol violation");
        end
    end
endmodule
`endif

module tlm_sb_rx_queue #(
    parameter int PC_DEPTH = 16,
    parameter int NP_DEPTH = 16
) (
    input  logic       tlm_secondary_clock,
    input  logic       tlm_secondary_reset,
    input  logic       sb2_tlm_pcput,
    input  logic       sb2_tlm_npput,
    input  logic       sb2_tlm_eom,
    input  logic [7:0] sb2_tlm_payload,
    output logic       tlm_sb2_pccup,
    output logic       tlm_sb2_npcup,
    output logic       rx_valid,
    output logic       rx_np,
    output logic [7:0] rx_data,
    output logic       rx_eom,
    input  logic       rx_ready,
    output logic       rx_ovf_err
);
    localparam int PC_PW = $clog2(PC_DEPTH) + 1;
    localparam int NP_PW = $clog2(NP_DEPTH) + 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = tlm_secondary_clock;
    assign rst_n = tlm_secondary_reset;

    state_t     state_q, state_d;
    logic [PC_PW-1:0] pc_init_q, pc_init_d, pc_pend_q, pc_pend_d;
    logic [NP_PW-1:0] np_init_q, np_init_d, np_pend_q, np_pend_d;
    logic       pccup_q, pccup_d, npcup_q, npcup_d;
    logic       lock_act_q, lock_act_d, lock_np_q, lock_np_d;

    logic       pc_push_s, np_push_s, pc_pop_s, np_pop_s;
    logic       pc_full_s, np_full_s, pc_avail_s, np_avail_s;
    logic [8:0] pc_head_s, np_head_s, head_s;
    logic       sel_np_s, valid_s, xfer_s;
    logic       pc_init_left_s, np_init_left_s;

    // A put into a full FIFO is dropped; with both puts high the NP flit is dropped.
    assign pc_push_s = sb2_tlm_pcput & ~pc_full_s;
    assign np_push_s = sb2_tlm_npput & ~sb2_tlm_pcput & ~np_full_s;

    tlm_sb_rx_fifo #(.DEPTH(PC_DEPTH)) u_pc_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pc_push_s),
        .wdata     ({sb2_tlm_eom, sb2_tlm_payload}),
        .pop       (pc_pop_s),
        .rdata     (pc_head_s),
        .full      (pc_full_s),
        .msg_avail (pc_avail_s)
    );

    tlm_sb_rx_fifo #(.DEPTH(NP_DEPTH)) u_np_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (np_push_s),
        .wdata     ({sb2_tlm_eom, sb2_tlm_payload}),
        .pop       (np_pop_s),
        .rdata     (np_head_s),
        .full      (np_full_s),
        .msg_avail (np_avail_s)
    );

    // Queue selection: locked class wins; otherwise PC before NP at a message boundary.
    always_comb begin
        sel_np_s = 1'b0;
        if (lock_act_q) begin
            sel_np_s = lock_np_q;
        end else if (pc_avail_s) begin
            sel_np_s = 1'b0;
        end else if (np_avail_s) begin
            sel_np_s = 1'b1;
        end else begin
            sel_np_s = 1'b0;
        end
    end

    assign valid_s  = sel_np_s ? np_avail_s : pc_avail_s;
    assign head_s   = sel_np_s ? np_head_s : pc_head_s;
    assign xfer_s   = valid_s & rx_ready;
    assign pc_pop_s = xfer_s & ~sel_np_s;
    assign np_pop_s = xfer_s & sel_np_s;

    assign rx_valid = valid_s;
    assign rx_np    = valid_s & sel_np_s;
    assign rx_data  = valid_s ? head_s[7:0] : 8'h00;
    assign rx_eom   = valid_s & head_s[8];

    // The lock is taken as soon as a flit is presented so a stalled head stays stable.
    always_comb begin
        lock_act_d = lock_act_q;
        lock_np_d  = lock_np_q;
        if (xfer_s && head_s[8]) begin
            lock_act_d = 1'b0;
            lock_np_d  = 1'b0;
        end else if (valid_s) begin
            lock_act_d = 1'b1;
            lock_np_d  = sel_np_s;
        end else begin
            lock_act_d = lock_act_q;
            lock_np_d  = lock_np_q;
        end
    end

    // INIT hands out the full depth of credits, then waits for both classes to finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if ((pc_init_q == PC_PW'(PC_DEPTH)) && (np_init_q == NP_PW'(NP_DEPTH))) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign pc_init_left_s = (state_q == ST_INIT) && (pc_init_q != PC_PW'(PC_DEPTH));
    assign np_init_left_s = (state_q == ST_INIT) && (np_init_q != NP_PW'(NP_DEPTH));

    // Credit pulses; pop credits arriving while init credits still flow are banked and paid later.
    always_comb begin
        pc_init_d = pc_init_q;
        pc_pend_d = pc_pend_q;
        pccup_d   = 1'b0;
        np_init_d = np_init_q;
        np_pend_d = np_pend_q;
        npcup_d   = 1'b0;
        if (pc_init_left_s) begin
            pccup_d   = 1'b1;
            pc_init_d = pc_init_q + PC_PW'(1);
            pc_pend_d = pc_pend_q + PC_PW'(pc_pop_s);
        end else if (pc_pop_s || (pc_pend_q != {PC_PW{1'b0}})) begin
            pccup_d   = 1'b1;
            pc_pend_d = pc_pend_q + PC_PW'(pc_pop_s) - PC_PW'(1);
        end else begin
            pccup_d   = 1'b0;
        end
        if (np_init_left_s) begin
            npcup_d   = 1'b1;
            np_init_d = np_init_q + NP_PW'(1);
            np_pend_d = np_pend_q + NP_PW'(np_pop_s);
        end else if (np_pop_s || (np_pend_q != {NP_PW{1'b0}})) begin
            npcup_d   = 1'b1;
            np_pend_d = np_pend_q + NP_PW'(np_pop_s) - NP_PW'(1);
        end else begin
            npcup_d   = 1'b0;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            pc_init_q  <= {PC_PW{1'b0}};
            pc_pend_q  <= {PC_PW{1'b0}};
            np_init_q  <= {NP_PW{1'b0}};
            np_pend_q  <= {NP_PW{1'b0}};
            pccup_q    <= 1'b0;
            npcup_q    <= 1'b0;
            lock_act_q <= 1'b0;
            lock_np_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_init_q  <= pc_init_d;
            pc_pend_q  <= pc_pend_d;
            np_init_q  <= np_init_d;
            np_pend_q  <= np_pend_d;
            pccup_q    <= pccup_d;
            npcup_q    <= npcup_d;
            lock_act_q <= lock_act_d;
            lock_np_q  <= lock_np_d;
        end
    end

    assign tlm_sb2_pccup = pccup_q;
    assign tlm_sb2_npcup = npcup_q;

`ifdef TLM_SB_RX_OVF_CHK_EN
    logic ovf_q, ovf_d;
    logic viol_s;

    assign viol_s = (sb2_tlm_pcput & pc_full_s)
                  | (sb2_tlm_npput & ~sb2_tlm_pcput & np_full_s)
                  | (sb2_tlm_pcput & sb2_tlm_npput)
                  | (sb2_tlm_eom & ~sb2_tlm_pcput & ~sb2_tlm_npput);

    // Sticky error flag, cleared only by reset.
    always_comb begin
        ovf_d = ovf_q;
        if (viol_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign rx_ovf_err = ovf_q;

    tlm_sb_rx_queue_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .viol  (viol_s)
    );
`else
    assign rx_ovf_err = 1'b0;
`endif
endmodule
